// File: rtl/led_blink_sched.sv
// Round-robin scheduler that lends one shared LED to three requesters in turn,
// blinking it cnt times with a half-period of hp time units for the served requester.
module led_blink_sched #(
    parameter int PRESCALE = 500
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [35:0] cfg,
    output logic        LED,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic        busy
);

    localparam int PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF, DONE} state_t;

    state_t        state, state_next;
    logic [1:0]    idx, idx_next, ptr, sel;
    logic [3:0]    cnt;
    logic [7:0]    hp;
    logic [PW-1:0] presc;
    logic [7:0]    unit;
    logic [11:0]   sel_cfg;
    logic          req_any, phase_end;
    logic          led_d;
    logic [2:0]    gnt_d, done_d;

    // Round-robin pick: first requester at or above ptr, wrapping modulo 3.
    always_comb begin
        req_any = |req;
        sel     = ptr;
        case (ptr)
            2'd0:    sel = req[0] ? 2'd0 : (req[1] ? 2'd1 : 2'd2);
            2'd1:    sel = req[1] ? 2'd1 : (req[2] ? 2'd2 : 2'd0);
            default: sel = req[2] ? 2'd2 : (req[0] ? 2'd0 : 2'd1);
        endcase
        case (sel)
            2'd0:    sel_cfg = cfg[11:0];
            2'd1:    sel_cfg = cfg[23:12];
            default: sel_cfg = cfg[35:24];
        endcase
    end

    assign phase_end = (presc == PRE_MAX) && (unit == hp - 8'd1);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            IDLE: begin
                if (req_any) begin
                    idx_next   = sel;
                    state_next = (sel_cfg[11:8] != 4'd0) ? ON : DONE;
                end
            end
            ON: begin
                if (phase_end) state_next = OFF;
            end
            OFF: begin
                if (phase_end) state_next = (cnt == 4'd1) ? DONE : ON;
            end
            default: state_next = IDLE;
        endcase
    end

    // Latched operation parameters and the prescaler/unit phase timer.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            idx   <= 2'd0;
            ptr   <= 2'd0;
            cnt   <= 4'd0;
            hp    <= 8'd0;
            presc <= '0;
            unit  <= 8'd0;
        end else begin
            idx <= idx_next;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        cnt <= sel_cfg[11:8];
                        hp  <= (sel_cfg[7:0] == 8'd0) ? 8'd1 : sel_cfg[7:0];
                    end
                    presc <= '0;
                    unit  <= 8'd0;
                end
                ON, OFF: begin
                    if (phase_end) begin
                        presc <= '0;
                        unit  <= 8'd0;
                        if (state == OFF) cnt <= cnt - 4'd1;
                    end else if (presc == PRE_MAX) begin
                        presc <= '0;
                        unit  <= unit + 8'd1;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                default: begin
                    ptr   <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
                    presc <= '0;
                    unit  <= 8'd0;
                end
            endcase
        end
    end

    // LED follows the ON state one cycle later; grant and done track the next state.
    always_comb begin
        led_d  = (state == ON);
        gnt_d  = (state_next != IDLE) ? (3'b001 << idx_next) : 3'b000;
        done_d = (state_next == DONE) ? (3'b001 << idx_next) : 3'b000;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            LED  <= 1'b0;
            gnt  <= 3'b000;
            done <= 3'b000;
        end else begin
            LED  <= led_d;
            gnt  <= gnt_d;
            done <= done_d;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_led_blink_sched.sv
// Self-checking bench for led_blink_sched: directed scenarios plus randomized traffic,
// all compared against a cycle-count reference model of each blink operation.
module tb_led_blink_sched;

    localparam int P = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req   = 3'b000;
    logic [35:0] cfg   = '0;
    logic        LED, busy;
    logic [2:0]  gnt, done;

    int tests = 0;
    int fails = 0;

    // Reference model: an operation is described by its start, length and period only.
    bit         m_active = 1'b0;
    int         m_idx = 0, m_t = 0, m_len = 0, m_T = 0, m_cnt = 0, m_ptr = 0;
    logic       m_led = 1'b0, m_busy = 1'b0;
    logic [2:0] m_gnt = 3'b000, m_done = 3'b000;

    led_blink_sched #(.PRESCALE(P)) dut (
        .CLOCK_50 (clock),
        .reset    (reset),
        .req      (req),
        .cfg      (cfg),
        .LED      (LED),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got no completion, required finish within time limit");
        $fatal(1);
    end

    function automatic logic [7:0] obs();
        return {LED, gnt, done, busy};
    endfunction

    function automatic logic [7:0] expv();
        return {m_led, m_gnt, m_done, m_busy};
    endfunction

    function automatic int pick(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++)
            if (r[(p + k) % 3]) return (p + k) % 3;
        return 0;
    endfunction

    task automatic model_step();
        int h, tm1;
        if (reset) begin
            m_active = 1'b0;
            m_ptr    = 0;
        end else if (!m_active) begin
            if (req != 3'b000) begin
                m_idx = pick(req, m_ptr);
                m_cnt = int'(cfg[12*m_idx+8 +: 4]);
                h     = int'(cfg[12*m_idx +: 8]);
                if (h == 0) h = 1;
                m_T      = h * P;
                m_len    = 2 * m_cnt * m_T + 1;
                m_t      = 0;
                m_active = 1'b1;
            end
        end else begin
            m_t++;
            if (m_t == m_len) begin
                m_active = 1'b0;
                m_ptr    = (m_idx + 1) % 3;
            end
        end
        m_busy = m_active;
        m_gnt  = m_active ? 3'(1 << m_idx) : 3'b000;
        m_done = (m_active && m_t == m_len - 1) ? 3'(1 << m_idx) : 3'b000;
        m_led  = 1'b0;
        if (m_active && m_t >= 1) begin
            tm1   = m_t - 1;
            m_led = ((tm1 % (2 * m_T)) < m_T) && (tm1 < 2 * m_cnt * m_T);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic set_cfg(input int i, input int c, input int h);
        cfg[12*i +: 12] = {4'(c), 8'(h)};
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 3'b000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 3'b000;
        tick();
        tick();
        tests++;
        if (obs() !== 8'h00) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got %b, required 00000000", obs());
        end
        req = 3'b111;
        for (int i = 0; i < 3; i++) set_cfg(i, 1, 1);
        for (int c = 0; c < 5; c++) begin
            tick();
            tests++;
            if (obs() !== 8'h00) begin
                fails++;
                $display("[TB] FAIL reset_held_no_grant: got %b, required 00000000", obs());
            end
        end
        reset = 1'b0;
        req   = 3'b000;
        for (int c = 0; c < 50; c++) begin
            tick();
            tests++;
            if (LED !== 1'b0 || obs() !== expv()) begin
                fails++;
                $display("[TB] FAIL idle_led_low cycle %0d: got %b, required %b", c, obs(), expv());
            end
        end
    endtask

    task automatic test_single();
        logic [15:0] pat = 16'b1111_0000_1111_0000;
        do_reset();
        cfg = '0;
        set_cfg(0, 2, 1);
        req = 3'b001;
        tick();
        tests++;
        if (gnt !== 3'b001 || LED !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL single_grant: got gnt=%b LED=%b busy=%b, required 001 0 1", gnt, LED, busy);
        end
        req = 3'b000;
        for (int t = 1; t <= 16; t++) begin
            tick();
            tests++;
            if (LED !== pat[16-t] || obs() !== expv()) begin
                fails++;
                $display("[TB] FAIL single_led t=%0d: got LED=%b all=%b, required LED=%b all=%b",
                         t, LED, obs(), pat[16-t], expv());
            end
        end
        tests++;
        if (done !== 3'b001 || gnt !== 3'b001) begin
            fails++;
            $display("[TB] FAIL single_done: got done=%b gnt=%b, required 001 001", done, gnt);
        end
        tick();
        tests++;
        if (obs() !== 8'h00) begin
            fails++;
            $display("[TB] FAIL single_release: got %b, required 00000000", obs());
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] order [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        logic [2:0] prev = 3'b000;
        int k = 0;
        int led_hi = 0;
        do_reset();
        for (int i = 0; i < 3; i++) set_cfg(i, 1, 1);
        req = 3'b111;
        for (int c = 0; c < 200 && k < 6; c++) begin
            tick();
            tests++;
            if (obs() !== expv()) begin
                fails++;
                $display("[TB] FAIL rr_model cycle %0d: got %b, required %b", c, obs(), expv());
            end
            if (gnt !== 3'b000 && prev === 3'b000) begin
                tests++;
                if (gnt !== order[k]) begin
                    fails++;
                    $display("[TB] FAIL rr_order #%0d: got gnt=%b, required %b", k, gnt, order[k]);
                end
            end
            if (LED === 1'b1) led_hi++;
            if (done !== 3'b000) begin
                tests++;
                if (done !== order[k] || led_hi != 4) begin
                    fails++;
                    $display("[TB] FAIL rr_done #%0d: got done=%b led_high=%0d, required %b 4",
                             k, done, led_hi, order[k]);
                end
                k++;
                led_hi = 0;
            end
            prev = gnt;
        end
        tests++;
        if (k != 6) begin
            fails++;
            $display("[TB] FAIL rr_timeout: got %0d completions, required 6", k);
        end
        req = 3'b000;
        tick();
        tick();
    endtask

    task automatic test_cnt_zero();
        do_reset();
        cfg = '0;
        set_cfg(1, 0, 5);
        req = 3'b010;
        tick();
        tests++;
        if (gnt !== 3'b010 || done !== 3'b010 || LED !== 1'b0) begin
            fails++;
            $display("[TB] FAIL cnt0_done: got gnt=%b done=%b LED=%b, required 010 010 0", gnt, done, LED);
        end
        req = 3'b000;
        tick();
        tests++;
        if (obs() !== 8'h00) begin
            fails++;
            $display("[TB] FAIL cnt0_release: got %b, required 00000000", obs());
        end
        req = 3'b111;
        tick();
        tests++;
        if (gnt !== 3'b100 || done !== 3'b100) begin
            fails++;
            $display("[TB] FAIL cnt0_ptr: got gnt=%b done=%b, required 100 100", gnt, done);
        end
        req = 3'b000;
        tick();
    endtask

    task automatic test_hp_edges();
        int hi;
        bit ok;
        do_reset();
        cfg = '0;
        set_cfg(0, 1, 0);
        set_cfg(1, 1, 255);
        req = 3'b001;
        tick();
        req = 3'b000;
        hi = 0;
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (LED === 1'b1) hi++;
            if (done !== 3'b000) begin ok = 1'b1; break; end
            tick();
            tests++;
            if (obs() !== expv()) begin
                fails++;
                $display("[TB] FAIL hp0_model: got %b, required %b", obs(), expv());
            end
        end
        tests++;
        if (!ok || hi != 4) begin
            fails++;
            $display("[TB] FAIL hp0_width: got done_seen=%0d led_high=%0d, required 1 4", ok, hi);
        end
        tick();
        req = 3'b010;
        tick();
        tests++;
        if (gnt !== 3'b010) begin
            fails++;
            $display("[TB] FAIL hp255_grant: got gnt=%b, required 010", gnt);
        end
        req = 3'b000;
        hi = 0;
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (LED === 1'b1) hi++;
            if (done !== 3'b000) begin ok = 1'b1; break; end
            tick();
            tests++;
            if (obs() !== expv()) begin
                fails++;
                $display("[TB] FAIL hp255_model: got %b, required %b", obs(), expv());
            end
        end
        tests++;
        if (!ok || hi != 1020) begin
            fails++;
            $display("[TB] FAIL hp255_width: got done_seen=%0d led_high=%0d, required 1 1020", ok, hi);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) set_cfg(i, 3, 1);
        req = 3'b001;
        tick();
        req = 3'b000;
        tick();
        tick();
        tests++;
        if (LED !== 1'b1 || gnt !== 3'b001) begin
            fails++;
            $display("[TB] FAIL midon_setup: got LED=%b gnt=%b, required 1 001", LED, gnt);
        end
        reset = 1'b1;
        tick();
        tests++;
        if (obs() !== 8'h00) begin
            fails++;
            $display("[TB] FAIL midon_abort: got %b, required 00000000", obs());
        end
        reset = 1'b0;
        req   = 3'b111;
        tick();
        tests++;
        if (gnt !== 3'b001 || done !== 3'b000) begin
            fails++;
            $display("[TB] FAIL midon_regrant: got gnt=%b done=%b, required 001 000", gnt, done);
        end
        req = 3'b000;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++)
                cfg[12*i +: 12] = {4'($urandom_range(0, 3)), 8'($urandom_range(0, 2))};
            if ($urandom_range(0, 7) == 0) req = 3'($urandom_range(0, 7));
            reset = ($urandom_range(0, 199) == 0);
            tick();
            tests++;
            if (obs() !== expv() || !$onehot0(gnt)) begin
                fails++;
                $display("[TB] FAIL random cycle %0d: got %b, required %b", c, obs(), expv());
            end
        end
        reset = 1'b0;
        req   = 3'b000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_cnt_zero();
        test_hp_edges();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/led_blink_sched.md
LED_BLINK_SCHED -- requirements
Module: led_blink_sched

Interface
REQ-001 Parameter PRESCALE, default 500, SHALL give the clock cycles per blink time unit (legal range >= 2).
REQ-002 CLOCK_50  input  1  SHALL be the single system clock; all logic is on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 req  input  3  SHALL carry one request per requester (bit i = requester i) and be level-sensitive.
REQ-005 cfg  input  36  SHALL hold requester i's config in bits [12i+11:12i] as {cnt[3:0], hp[7:0]}:
  - cnt = number of blinks;
  - hp = half-period in time units.
REQ-006 LED  output  1  SHALL be the shared LED drive, registered.
REQ-007 gnt  output  3  SHALL be the one-hot grant, registered, all zero when no requester is served.
REQ-008 done  output  3  SHALL give a one-cycle completion pulse for the served requester, registered.
REQ-009 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-010 FSM states SHALL be IDLE, ON, OFF and DONE.
REQ-011 IDLE with req != 0 SHALL select the first set bit scanning from pointer ptr upward, mod 3.
REQ-012 On selection the block SHALL latch idx, cnt and hp from cfg; later cfg/req changes SHALL NOT affect the operation in progress.
REQ-013 A latched hp of 0 SHALL be treated as 1.
REQ-014 State SHALL go to ON if cnt != 0, else to DONE, with gnt[idx] = 1 from the next cycle.
REQ-015 In ON, LED SHALL be 1 for exactly hp*PRESCALE cycles, then the state goes to OFF.
REQ-016 In OFF, LED SHALL be 0 for exactly hp*PRESCALE cycles, then the remaining count is decremented.
REQ-017 On leaving OFF the state SHALL go to DONE if the remaining count reaches 0, else back to ON.
REQ-018 Phase timing SHALL use a prescaler of width clog2(PRESCALE) plus an 8-bit unit counter, both cleared on every phase entry; no overflow is permitted at hp = 255.
REQ-019 DONE SHALL last exactly one cycle:
  - done[idx] = 1, gnt[idx] still 1;
  - ptr = (idx+1) mod 3;
  - next state IDLE.
REQ-020 In the cycle after DONE, gnt SHALL be 0 and LED 0.
REQ-021 Arbitration SHALL occur no earlier than the IDLE cycle, so there are at least 2 cycles between consecutive grants.
REQ-022 Deasserting req[idx] while granted SHALL be ignored; the operation completes.
REQ-023 Requests arriving during an operation SHALL wait; no request SHALL be lost while held.
REQ-024 LED SHALL be 1 only in ON, and gnt SHALL never have more than one bit set.
REQ-025 The latency from req rising in IDLE to LED = 1 SHALL be 2 cycles: one to latch/grant, one for the registered LED.

Reset
REQ-026 reset = 1 at a rising edge SHALL force, on the next cycle: IDLE, LED = 0, gnt = 0, done = 0, busy = 0, ptr = 0, counters 0.
REQ-027 Reset SHALL take priority over every transition, including mid-ON/OFF/DONE; the aborted requester SHALL get no done pulse.
REQ-028 Reset held high SHALL keep all outputs at their reset values and SHALL NOT grant.

Verification (PRESCALE = 4)
REQ-029 Reset pulse for 1 cycle with req = 0 -> LED = 0, gnt = 0, done = 0, busy = 0; LED stays 0 for 50 cycles.
REQ-030 req = 001, cnt = 2, hp = 1 -> expected response:
  - gnt = 001;
  - LED pattern 1x4, 0x4, 1x4, 0x4;
  - done[0] pulse in the cycle after the last OFF cycle;
  - gnt = 0 in the cycle after that.
REQ-031 req = 111 held, all cnt = 1, hp = 1 -> grants 001, 010, 100, 001, ...; each grant gives 4 LED-high cycles; done pulses in the same order.
REQ-032 req = 010 with cnt = 0 -> one-cycle grant cycle, then DONE with done[1] = 1; LED never 1; ptr becomes 2.
REQ-033 Request with hp = 0, cnt = 1 -> LED high exactly 4 cycles; hp = 255 -> LED high exactly 1020 cycles.
REQ-034 reset asserted mid-ON of a cnt = 3 operation -> LED = 0, gnt = 0 next cycle, no done pulse, and the next grant goes to requester 0 when req = 111.
